// File: rtl/nios_fprint_multi_timer_pkg.sv
// Shared definitions for the nios_fprint_multi_timer slice.
//   - per-channel register offsets (address bits [2:0])
//   - STATUS / CONTROL bit positions
//   - chan_csr_t: the per-channel control/status register state
package nios_fprint_multi_timer_pkg;

  localparam logic [2:0] REG_STATUS    = 3'd0;
  localparam logic [2:0] REG_CONTROL   = 3'd1;
  localparam logic [2:0] REG_PERIOD_LO = 3'd2;
  localparam logic [2:0] REG_PERIOD_HI = 3'd3;
  localparam logic [2:0] REG_SNAP_LO   = 3'd4;
  localparam logic [2:0] REG_SNAP_HI   = 3'd5;
  localparam logic [2:0] REG_PRESCALE  = 3'd6;

  localparam int unsigned STAT_TO    = 0;
  localparam int unsigned STAT_RUN   = 1;
  localparam int unsigned CTRL_ITO   = 0;
  localparam int unsigned CTRL_CONT  = 1;
  localparam int unsigned CTRL_START = 2;
  localparam int unsigned CTRL_STOP  = 3;

  typedef struct packed {
    logic ito;   // interrupt enable
    logic cont;  // continuous (1) / one-shot (0)
    logic run;   // counter running
    logic to;    // sticky timeout flag
  } chan_csr_t;

endpackage

// File: rtl/nios_fprint_multi_timer_channel.sv
// One timer channel: down-counter, period, snapshot, control/status and the
// optional prescaler (macro NIOS_FPRINT_MULTI_TIMER_PRESCALE_EN).
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   wr_i             write strobe addressed to this channel
//   reg_i [2:0]      register offset (write and read)
//   wdata_i [31:0]   write data
//   rdata_o [31:0]   combinational read value of register reg_i
//   irq_o            TO & ITO
module nios_fprint_multi_timer_channel
  import nios_fprint_multi_timer_pkg::*;
#(
  parameter int unsigned COUNT_W    = 64,
  parameter logic [63:0] PERIOD_RST = 64'd49999,
  parameter int unsigned PRE_W      = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_i,
  input  logic [2:0]  reg_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  localparam logic [COUNT_W-1:0] PER_RST = PERIOD_RST[COUNT_W-1:0];

  logic [COUNT_W-1:0] cnt_q, cnt_d, period_q, period_d, snap_q, snap_d;
  chan_csr_t          csr_q, csr_d;
  logic               reload_q, reload_d;
  logic               zero_q, zero_d;
  logic               tick, evt;
  logic [31:0]        pre_rd;
  logic [63:0]        per64, new64, snap64;

`ifdef NIOS_FPRINT_MULTI_TIMER_PRESCALE_EN
  logic [PRE_W-1:0] pre_q, pre_d, pre_rld_q, pre_rld_d;

  assign tick   = (pre_q == '0);
  assign pre_rd = 32'(pre_rld_q);

  always_comb begin
    pre_rld_d = pre_rld_q;
    if (wr_i && reg_i == REG_PRESCALE) pre_rld_d = wdata_i[PRE_W-1:0];
    if (!csr_q.run)          pre_d = pre_rld_q;
    else if (pre_q == '0)    pre_d = pre_rld_q;
    else                     pre_d = pre_q - PRE_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_q     <= '0;
      pre_rld_q <= '0;
    end else begin
      pre_q     <= pre_d;
      pre_rld_q <= pre_rld_d;
    end
  end
`else
  assign tick   = 1'b1;
  assign pre_rd = 32'({PRE_W{1'b0}});
`endif

  // Zero-edge detection is sampled on counting ticks, so with a prescaler the
  // timeout lines up with the reload; without one it is a plain rising edge.
  assign evt = tick && (cnt_q == '0) && !zero_q;

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    snap_d   = snap_q;
    csr_d    = csr_q;
    reload_d = 1'b0;
    zero_d   = zero_q;
    per64    = 64'(period_q);
    new64    = per64;

    if (wr_i) begin
      case (reg_i)
        REG_STATUS:  csr_d.to = 1'b0;
        REG_CONTROL: begin
          csr_d.ito  = wdata_i[CTRL_ITO];
          csr_d.cont = wdata_i[CTRL_CONT];
        end
        REG_PERIOD_LO: begin
          new64[31:0] = wdata_i;
          period_d    = new64[COUNT_W-1:0];
          reload_d    = 1'b1;
        end
        REG_PERIOD_HI: begin
          new64[63:32] = wdata_i;
          period_d     = new64[COUNT_W-1:0];
          reload_d     = 1'b1;
        end
        REG_SNAP_LO, REG_SNAP_HI: snap_d = cnt_q;
        default: ;
      endcase
    end

    if (reload_q)
      cnt_d = period_q;
    else if (csr_q.run && tick)
      cnt_d = (cnt_q == '0) ? period_q : cnt_q - COUNT_W'(1);

    if (wr_i && reg_i == REG_CONTROL && wdata_i[CTRL_START])
      csr_d.run = 1'b1;
    else if ((wr_i && reg_i == REG_CONTROL && wdata_i[CTRL_STOP]) || reload_q)
      csr_d.run = 1'b0;
    else if (csr_q.run && tick && cnt_q == '0 && !csr_q.cont)
      csr_d.run = 1'b0;

    if (tick) zero_d = (cnt_q == '0);
    // Applied after the STATUS clear so a coincident timeout is not lost.
    if (evt) csr_d.to = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= PER_RST;
      period_q <= PER_RST;
      snap_q   <= '0;
      csr_q    <= '0;
      reload_q <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      snap_q   <= snap_d;
      csr_q    <= csr_d;
      reload_q <= reload_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    snap64  = 64'(snap_q);
    case (reg_i)
      REG_STATUS: begin
        rdata_o[STAT_TO]  = csr_q.to;
        rdata_o[STAT_RUN] = csr_q.run;
      end
      REG_CONTROL: begin
        rdata_o[CTRL_ITO]  = csr_q.ito;
        rdata_o[CTRL_CONT] = csr_q.cont;
      end
      REG_PERIOD_LO: rdata_o = per64[31:0];
      REG_PERIOD_HI: rdata_o = per64[63:32];
      REG_SNAP_LO:   rdata_o = snap64[31:0];
      REG_SNAP_HI:   rdata_o = snap64[63:32];
      REG_PRESCALE:  rdata_o = pre_rd;
      default:       rdata_o = '0;
    endcase
  end

  assign irq_o = csr_q.to & csr_q.ito;

endmodule

// File: rtl/nios_fprint_multi_timer.sv
// Multi-channel interval timer, Avalon-MM slave.
// Optional prescaler per channel: define NIOS_FPRINT_MULTI_TIMER_PRESCALE_EN.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   address         {channel, reg[2:0]}
//   chipselect      slave select; write_n low = write, high = read
//   writedata       write data
//   readdata        registered read data, valid the cycle after the access
//   irq             OR of irq_vec
//   irq_vec         per-channel TO & ITO
module nios_fprint_multi_timer
  import nios_fprint_multi_timer_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned COUNT_W    = 64,
  parameter logic [63:0] PERIOD_RST = 64'd49999,
  parameter int unsigned PRE_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(NUM_CH)+2:0]   address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  output logic                        irq,
  output logic [NUM_CH-1:0]           irq_vec
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CH_W-1:0] ch_sel;
  logic [2:0]      reg_sel;
  logic [31:0]     ch_rdata [NUM_CH];
  logic [31:0]     rd_mux;
  logic [31:0]     readdata_q, readdata_d;

  assign ch_sel  = CH_W'(address >> 3);
  assign reg_sel = address[2:0];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    nios_fprint_multi_timer_channel #(
      .COUNT_W    (COUNT_W),
      .PERIOD_RST (PERIOD_RST),
      .PRE_W      (PRE_W)
    ) u_ch (
      .clk_i   (clk),
      .rst_i   (reset),
      .wr_i    (chipselect && !write_n && (ch_sel == CH_W'(g))),
      .reg_i   (reg_sel),
      .wdata_i (writedata),
      .rdata_o (ch_rdata[g]),
      .irq_o   (irq_vec[g])
    );
  end

  // Channel indices with no instance fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      if (ch_sel == CH_W'(i)) rd_mux = ch_rdata[i];
    readdata_d = (chipselect && write_n) ? rd_mux : readdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;
  assign irq      = |irq_vec;

endmodule

// File: tb/tb_nios_fprint_multi_timer.sv
// Directed self-checking bench for nios_fprint_multi_timer (default parameters).
module tb_nios_fprint_multi_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  irq_vec;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  nios_fprint_multi_timer dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_vec    (irq_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; access is sampled at the next posedge; returns at the following negedge.
  task automatic bus_wr(input logic [1:0] ch, input logic [2:0] r, input logic [31:0] d);
    address = {ch, r}; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] ch, input logic [2:0] r,
                        input logic [31:0] exp);
    address = {ch, r}; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    chk(tag, 64'(readdata), 64'(exp));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_irqvec", 64'(irq_vec), 64'd0);
    chk("rst_rdata", 64'(readdata), 64'd0);
    rd_chk("rst_per_lo", 2'd0, 3'd2, 32'h0000C34F);
    rd_chk("rst_per_hi", 2'd0, 3'd3, 32'h0);
    rd_chk("rst_status", 2'd0, 3'd0, 32'h0);
    rd_chk("rst_ctrl", 2'd3, 3'd1, 32'h0);
    rd_chk("rst_resv", 2'd1, 3'd7, 32'h0);

    // Ch1 continuous, period 9: timeout 10 clk after START, then every 10 clk
    bus_wr(2'd1, 3'd2, 32'd9);
    bus_wr(2'd1, 3'd1, 32'h7);
    repeat (9) @(negedge clk);
    chk("ch1_pre_to", 64'(irq_vec[1]), 64'd0);
    @(negedge clk);
    chk("ch1_to1", 64'(irq_vec[1]), 64'd1);
    bus_wr(2'd1, 3'd0, 32'h0);
    chk("ch1_clr", 64'(irq_vec[1]), 64'd0);
    repeat (8) @(negedge clk);
    chk("ch1_pre_to2", 64'(irq_vec[1]), 64'd0);
    @(negedge clk);
    chk("ch1_to2", 64'(irq_vec[1]), 64'd1);
    bus_wr(2'd1, 3'd0, 32'h0);
    repeat (8) @(negedge clk);
    chk("ch1_pre_to3", 64'(irq_vec[1]), 64'd0);
    // STATUS write lands in the same cycle as the timeout event
    bus_wr(2'd1, 3'd0, 32'h0);
    chk("coinc_irqvec", 64'(irq_vec[1]), 64'd1);
    chk("coinc_irq", 64'(irq), 64'd1);
    rd_chk("coinc_status", 2'd1, 3'd0, 32'h3);
    bus_wr(2'd1, 3'd1, 32'h8);
    bus_wr(2'd1, 3'd0, 32'h0);
    rd_chk("ch1_stopped", 2'd1, 3'd0, 32'h0);
    chk("ch1_irq_off", 64'(irq), 64'd0);

    // Ch2 one-shot, period 3
    bus_wr(2'd2, 3'd2, 32'd3);
    bus_wr(2'd2, 3'd1, 32'h5);
    repeat (8) @(negedge clk);
    rd_chk("ch2_status", 2'd2, 3'd0, 32'h1);
    chk("ch2_irq", 64'(irq_vec), 64'h4);
    bus_wr(2'd2, 3'd4, 32'h0);
    rd_chk("ch2_snap_lo", 2'd2, 3'd4, 32'd3);
    rd_chk("ch2_snap_hi", 2'd2, 3'd5, 32'd0);
    bus_wr(2'd2, 3'd0, 32'h0);
    repeat (12) @(negedge clk);
    chk("ch2_single", 64'(irq_vec), 64'h0);
    rd_chk("ch2_status2", 2'd2, 3'd0, 32'h0);

    // Ch0 snapshot while running
    bus_wr(2'd0, 3'd2, 32'h1240);
    bus_wr(2'd0, 3'd1, 32'h6);
    repeat (12) @(negedge clk);
    bus_wr(2'd0, 3'd4, 32'h0);
    rd_chk("ch0_snap1", 2'd0, 3'd4, 32'h1234);
    bus_wr(2'd0, 3'd5, 32'h0);
    rd_chk("ch0_snap2", 2'd0, 3'd4, 32'h1232);
    rd_chk("ch0_snap2_hi", 2'd0, 3'd5, 32'h0);
    rd_chk("ch0_running", 2'd0, 3'd0, 32'h2);

    // Period write forces reload and clears RUN
    bus_wr(2'd0, 3'd2, 32'h20);
    @(negedge clk);
    rd_chk("perwr_run", 2'd0, 3'd0, 32'h0);
    bus_wr(2'd0, 3'd4, 32'h0);
    rd_chk("perwr_cnt", 2'd0, 3'd4, 32'h20);
    bus_wr(2'd0, 3'd3, 32'hABCD);
    rd_chk("per_hi", 2'd0, 3'd3, 32'hABCD);
    rd_chk("per_lo_kept", 2'd0, 3'd2, 32'h20);
    bus_wr(2'd0, 3'd3, 32'h0);

    // START and STOP together: START wins; strobes read back as 0
    bus_wr(2'd3, 3'd2, 32'h100);
    bus_wr(2'd3, 3'd1, 32'hE);
    rd_chk("ss_run", 2'd3, 3'd0, 32'h2);
    rd_chk("ss_ctrl", 2'd3, 3'd1, 32'h2);
    bus_wr(2'd3, 3'd1, 32'h8);
    rd_chk("stop_run", 2'd3, 3'd0, 32'h0);

    // Period 0: one timeout only
    bus_wr(2'd3, 3'd2, 32'h0);
    repeat (3) @(negedge clk);
    rd_chk("p0_to", 2'd3, 3'd0, 32'h1);
    bus_wr(2'd3, 3'd1, 32'h6);
    bus_wr(2'd3, 3'd0, 32'h0);
    repeat (10) @(negedge clk);
    rd_chk("p0_once", 2'd3, 3'd0, 32'h2);
    bus_wr(2'd3, 3'd1, 32'h8);

    // Prescaler
`ifdef NIOS_FPRINT_MULTI_TIMER_PRESCALE_EN
    bus_wr(2'd0, 3'd6, 32'd4);
    rd_chk("pre_rd", 2'd0, 3'd6, 32'd4);
    bus_wr(2'd0, 3'd2, 32'd1);
    bus_wr(2'd0, 3'd1, 32'h7);
    repeat (9) @(negedge clk);
    chk("pre_pre_to", 64'(irq_vec[0]), 64'd0);
    @(negedge clk);
    chk("pre_to", 64'(irq_vec[0]), 64'd1);
`else
    bus_wr(2'd0, 3'd6, 32'd4);
    rd_chk("pre_rd0", 2'd0, 3'd6, 32'd0);
`endif

    // Asynchronous reset mid-operation with a pending interrupt
    bus_wr(2'd1, 3'd2, 32'd9);
    bus_wr(2'd1, 3'd1, 32'h7);
    bus_wr(2'd0, 3'd4, 32'h0);
    repeat (12) @(negedge clk);
    chk("pre_rst_irq", 64'(irq), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_irq", 64'(irq), 64'd0);
    chk("arst_irqvec", 64'(irq_vec), 64'd0);
    chk("arst_rdata", 64'(readdata), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rd_chk("arst_status", 2'd1, 3'd0, 32'h0);
    rd_chk("arst_ctrl", 2'd1, 3'd1, 32'h0);
    rd_chk("arst_per", 2'd1, 3'd2, 32'h0000C34F);
    rd_chk("arst_snap", 2'd0, 3'd4, 32'h0);
    repeat (5) @(negedge clk);
    chk("arst_irq_hold", 64'(irq), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
